optoml_elastic_buffer: RTL and testbench

Parametrised multi-entry valid/ready elastic buffer. It is the successor to the single-register stream slice, for deeper decoupling between pipeline stages. It provides DEPTH-entry FIFO storage, full throughput with concurrent push and pop, an occupancy level, an almost-full flag and a synchronous flush. in_ready and out_valid have no combinational path from the opposite side, so instances cascade without long timing paths.

---
 rtl/optoml_elastic_buffer.sv | 61 ++++++
 tb/tb_optoml_elastic_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/optoml_elastic_buffer.sv
// optoml_elastic_buffer: DEPTH-entry valid/ready FIFO slice with level, almost-full and flush.
// in_ready/out_valid come from registered level only, so instances cascade cleanly.
module optoml_elastic_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] AF = LW'(AF_THRESH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_params
    $error("optoml_elastic_buffer: DEPTH must be >= 2 and 1 <= AF_THRESH <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;

  always_comb begin
    in_ready = level < FULL;
    out_valid = level != '0;
    almost_full = level >= AF;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    out_data = out_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clock)
    if (push && !flush) mem[wr_ptr] <= in_data;

  // explicit wrap compare keeps non-power-of-two depths correct
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      level <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      level <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
endmodule

// File: tb/tb_optoml_elastic_buffer.sv
// tb_optoml_elastic_buffer: directed stimulus on a DEPTH=4 buffer plus random traffic on DEPTH=3,
// checked by queue-based monitors that sample at the falling edge.
module tb_optoml_elastic_buffer;
  logic clock = 0;
  logic resetn = 0;
  always #5 clock = ~clock;

  logic        flush4 = 0, in_valid4 = 0, out_ready4 = 0, in_ready4, out_valid4, af4;
  logic [31:0] in_data4 = 0, out_data4;
  logic [2:0]  level4;
  logic        flush3 = 0, in_valid3 = 0, out_ready3 = 0, in_ready3, out_valid3, af3;
  logic [31:0] in_data3 = 0, out_data3;
  logic [1:0]  level3;

  optoml_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4), .AF_THRESH(3)) u4 (
    .clock(clock), .resetn(resetn), .flush(flush4), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready4),
    .level(level4), .almost_full(af4));

  optoml_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(3)) u3 (
    .clock(clock), .resetn(resetn), .flush(flush3), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready3),
    .level(level3), .almost_full(af3));

  int total = 0, bad = 0;
  logic [31:0] q4[$], q3[$];
  int m4 = 0, m3 = 0;
  bit done3 = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask

  // model of the DEPTH=4 instance; update reflects the handshake at the next rising edge
  always @(negedge clock) begin
    if (!resetn) begin
      chk("rst_lvl4", 32'(level4), 0);
      chk("rst_rdy4", 32'(in_ready4), 1);
      chk("rst_vld4", 32'(out_valid4), 0);
      chk("rst_af4", 32'(af4), 0);
      chk("rst_dat4", out_data4, 0);
      q4.delete();
      m4 = 0;
    end else begin
      automatic bit p = in_valid4 && m4 < 4;
      chk("lvl4", 32'(level4), 32'(m4));
      chk("rdy4", 32'(in_ready4), 32'(m4 < 4));
      chk("vld4", 32'(out_valid4), 32'(m4 != 0));
      chk("af4", 32'(af4), 32'(m4 >= 3));
      chk("dat4", out_data4, m4 != 0 ? q4[0] : 32'h0);
      if (flush4) begin
        q4.delete();
        m4 = 0;
      end else begin
        if (out_ready4 && m4 != 0) begin
          void'(q4.pop_front());
          m4--;
        end
        if (p) begin
          q4.push_back(in_data4);
          m4++;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!resetn) begin
      chk("rst_lvl3", 32'(level3), 0);
      chk("rst_vld3", 32'(out_valid3), 0);
      q3.delete();
      m3 = 0;
    end else begin
      automatic bit p = in_valid3 && m3 < 3;
      chk("lvl3", 32'(level3), 32'(m3));
      chk("rdy3", 32'(in_ready3), 32'(m3 < 3));
      chk("vld3", 32'(out_valid3), 32'(m3 != 0));
      chk("af3", 32'(af3), 32'(m3 >= 2));
      chk("dat3", out_data3, m3 != 0 ? q3[0] : 32'h0);
      if (out_ready3 && m3 != 0) begin
        void'(q3.pop_front());
        m3--;
      end
      if (p) begin
        q3.push_back(in_data3);
        m3++;
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] d, input bit r, input bit f);
    @(posedge clock);
    #1;
    in_valid4 = v;
    in_data4 = d;
    out_ready4 = r;
    flush4 = f;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    while (!resetn) @(posedge clock);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock);
      #1;
      in_valid3 = 1'($urandom_range(0, 1));
      in_data3 = $urandom;
      out_ready3 = 1'($urandom_range(0, 1));
    end
    in_valid3 = 0;
    out_ready3 = 1;
    repeat (5) @(posedge clock);
    done3 = 1;
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 resetn = 1;
    for (int i = 1; i <= 3; i++) drive(1, 32'(i), 1, 0);
    repeat (3) drive(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 32'hA0 + 32'(i), 0, 0);
    repeat (2) drive(1, 32'hA4, 0, 0);
    for (int i = 0; i < 13; i++) drive(1, 32'hB0 + 32'(i), 1, 0);
    repeat (5) drive(0, 0, 1, 0);
    drive(1, 32'hD0, 0, 0);
    drive(1, 32'hD1, 0, 0);
    drive(1, 32'hFF, 1, 1);
    repeat (3) drive(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 32'hE0 + 32'(i), 0, 0);
    for (int i = 3; i < 6; i++) drive(1, 32'hE0 + 32'(i), 1, 0);
    @(posedge clock);
    #3 resetn = 0;
    #1;
    chk("async_lvl4", 32'(level4), 0);
    chk("async_vld4", 32'(out_valid4), 0);
    chk("async_rdy4", 32'(in_ready4), 1);
    chk("async_dat4", out_data4, 0);
    @(posedge clock);
    #1 resetn = 1;
    drive(1, 32'hC0, 1, 0);
    drive(1, 32'hC1, 1, 0);
    repeat (4) drive(0, 0, 1, 0);
    for (int i = 0; i < 2000 && !done3; i++) @(posedge clock);
    if (!done3) chk("random_done", 0, 1);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
